// File: rtl/btn_evq_pkg.sv
// Shared constants, entry type and word formatters for the button event queue.
// Optional timestamping is enabled with the BTN_EVQ_TSTAMP_EN macro.
package btn_evq_pkg;

  localparam logic [31:0] DATA_AD_DEF = 32'h1100_0060;
  localparam logic [31:0] STAT_AD_DEF = 32'h1100_0064;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

  localparam int CTL_FLUSH   = 0;
  localparam int CTL_CLR_OVF = 1;

  localparam int TS_W   = 16;
  localparam int MASK_W = 4;

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [MASK_W-1:0] mask;
  } btn_evq_entry_t;

  // Head-of-queue word; all zero when nothing is queued.
  function automatic logic [31:0] data_word(
    input logic              vld,
    input logic [TS_W-1:0]   ts,
    input logic [MASK_W-1:0] mask
  );
    logic [31:0] w;
    w = '0;
    if (vld) begin
      w[31]    = 1'b1;
      w[27:12] = ts;
      w[3:0]   = mask;
    end
    return w;
  endfunction

  function automatic logic [31:0] stat_word(
    input logic       empty,
    input logic       full,
    input logic       ovf,
    input logic [7:0] cnt
  );
    logic [31:0] w;
    w           = '0;
    w[ST_EMPTY] = empty;
    w[ST_FULL]  = full;
    w[ST_OVF]   = ovf;
    w[15:8]     = cnt;
    return w;
  endfunction

endpackage

// File: rtl/btn_evq_fifo.sv
// Generic synchronous FIFO with push, pop and flush.
// Flush beats push and pop; a push into a full FIFO is taken only with a pop.
module btn_evq_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   push_ok_o,
  output logic                   pop_ok_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  assign pop_ok  = pop_i && !empty_o && !flush_i;
  assign push_ok = push_i && !flush_i
                && (!full_o || pop_ok);

  assign push_ok_o = push_ok;
  assign pop_ok_o  = pop_ok;

  // Pointer and occupancy arithmetic; pointers wrap by width.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + AW'(1);
      if (pop_ok)  rd_d = rd_q + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; stale slots are never exposed.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/mmio_btn_event_queue.sv
// MMIO button event queue: one-shots in, popped by CPU reads, INTR out.
// Define BTN_EVQ_TSTAMP_EN to store a millisecond-tick timestamp per event.
module mmio_btn_event_queue
  import btn_evq_pkg::*;
#(
  parameter int          DEPTH       = 8,
  parameter logic [31:0] DATA_AD     = DATA_AD_DEF,
  parameter logic [31:0] STAT_AD     = STAT_AD_DEF,
  parameter int          TS_PRESCALE = 50000
) (
  input  logic        CLK_50,
  input  logic        RST,
  input  logic [3:0]  BTN_PULSE,
  input  logic [31:0] IOBUS_ADDR,
  input  logic        IOBUS_RD,
  input  logic        IOBUS_WR,
  input  logic [31:0] IOBUS_OUT,
  output logic [31:0] RD_DATA,
  output logic        INTR
);

`ifdef BTN_EVQ_TSTAMP_EN
  localparam int EW = $bits(btn_evq_entry_t);
`else
  localparam int EW = MASK_W;
`endif
  localparam int CW = $clog2(DEPTH) + 1;

  logic          sel_data, sel_stat;
  logic          pop_req, push_req;
  logic          ctl_wr, flush, clr_ovf;
  logic [EW-1:0] wdata, rdata;
  logic [CW-1:0] count;
  logic          full, empty, push_ok, pop_ok;
  logic [15:0]   head_ts;
  logic [3:0]    head_mask;
  logic          ovf_q, ovf_d;
  logic          intr_q, intr_d;
  logic          unused_ok;

  assign sel_data = (IOBUS_ADDR == DATA_AD);
  assign sel_stat = (IOBUS_ADDR == STAT_AD);
  assign pop_req  = IOBUS_RD && sel_data;
  assign push_req = |BTN_PULSE;
  assign ctl_wr   = IOBUS_WR && sel_stat;
  assign flush    = ctl_wr && IOBUS_OUT[CTL_FLUSH];
  assign clr_ovf  = ctl_wr && IOBUS_OUT[CTL_CLR_OVF];

  assign unused_ok = ^IOBUS_OUT[31:2];

  btn_evq_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk_i     (CLK_50),
    .rst_i     (RST),
    .push_i    (push_req),
    .pop_i     (pop_req),
    .flush_i   (flush),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty),
    .push_ok_o (push_ok),
    .pop_ok_o  (pop_ok)
  );

`ifdef BTN_EVQ_TSTAMP_EN
  logic [31:0]    pre_q, pre_d;
  logic [15:0]    tick_q, tick_d;
  btn_evq_entry_t wr_e, hd_e;

  // Prescaler wraps every TS_PRESCALE cycles and bumps the tick.
  always_comb begin
    pre_d  = pre_q + 32'd1;
    tick_d = tick_q;
    if (pre_q == 32'(TS_PRESCALE - 1)) begin
      pre_d  = '0;
      tick_d = tick_q + 16'd1;
    end
  end

  // Timestamp counters.
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      pre_q  <= '0;
      tick_q <= '0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  assign wr_e.ts   = tick_q;
  assign wr_e.mask = BTN_PULSE;
  assign wdata     = wr_e;
  assign hd_e      = rdata;
  assign head_ts   = hd_e.ts;
  assign head_mask = hd_e.mask;
`else
  localparam int unused_ts_prescale = TS_PRESCALE;

  assign wdata     = BTN_PULSE;
  assign head_ts   = '0;
  assign head_mask = rdata;
`endif

  // Sticky overflow; a new drop wins over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (push_req && full && !pop_ok && !flush)
      ovf_d = 1'b1;
  end

  assign intr_d = push_ok;

  // Overflow flag and one-cycle interrupt pulse.
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      ovf_q  <= 1'b0;
      intr_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      intr_q <= intr_d;
    end
  end

  assign INTR = intr_q;

  // Read mux is address-driven; the pop happens at the edge.
  always_comb begin
    RD_DATA = '0;
    unique case (1'b1)
      sel_data: RD_DATA = data_word(!empty, head_ts, head_mask);
      sel_stat: RD_DATA = stat_word(empty, full, ovf_q, 8'(count));
      default:  RD_DATA = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_btn_event_queue.sv
// Scoreboard bench for mmio_btn_event_queue.
// Stimulus queues expectations by cycle; a negedge monitor checks them.
module tb_mmio_btn_event_queue;

  localparam logic [31:0] DAT = 32'h1100_0060;
  localparam logic [31:0] STA = 32'h1100_0064;
  localparam logic [31:0] FRN = 32'h1100_0068;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  btn;
  logic [31:0] addr;
  logic        rd_s;
  logic        wr_s;
  logic [31:0] wdat;
  logic [31:0] rdata;
  logic        intr;

  int cyc_cnt = 0;
  int n_chk   = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    bit          is_intr;
    logic [31:0] exp;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  always #10 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  mmio_btn_event_queue #(
    .DEPTH       (8),
    .DATA_AD     (DAT),
    .STAT_AD     (STA),
    .TS_PRESCALE (4)
  ) dut (
    .CLK_50     (clk),
    .RST        (rst),
    .BTN_PULSE  (btn),
    .IOBUS_ADDR (addr),
    .IOBUS_RD   (rd_s),
    .IOBUS_WR   (wr_s),
    .IOBUS_OUT  (wdat),
    .RD_DATA    (rdata),
    .INTR       (intr)
  );

  function automatic void sb_put(exp_t e);
    int i = sb.size();
    while (i > 0 && sb[i-1].cyc > e.cyc) i--;
    sb.insert(i, e);
  endfunction

  function automatic void ex(string n, bit ii,
                             logic [31:0] v, int off);
    exp_t e;
    e.name    = n;
    e.is_intr = ii;
    e.exp     = v;
    e.cyc     = cyc_cnt + off;
    sb_put(e);
  endfunction

  // Monitor: compares everything due in the current cycle.
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      e   = sb.pop_front();
      act = e.is_intr ? {31'b0, intr} : rdata;
      n_chk++;
      if (e.cyc != cyc_cnt) begin
        n_fail++;
        $display("FAIL %s: stale check for cycle %0d at %0d",
                 e.name, e.cyc, cyc_cnt);
      end else if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %08h want %08h",
                 e.name, act, e.exp);
      end
    end
  end

  task automatic idle();
    rst  = 1'b0;
    btn  = '0;
    addr = '0;
    rd_s = 1'b0;
    wr_s = 1'b0;
    wdat = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(logic [31:0] a, string n, logic [31:0] v);
    addr = a;
    rd_s = 1'b1;
    ex(n, 1'b0, v, 0);
  endtask

  task automatic wr_stat(logic [31:0] v);
    addr = STA;
    wr_s = 1'b1;
    wdat = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    idle();

`ifdef BTN_EVQ_TSTAMP_EN
    rst = 1'b1;
    step();
    btn = 4'b0001;
    step();
    repeat (9) step();
    btn = 4'b0010;
    step();
    rd(DAT, "ts_first", 32'h8000_0001);
    step();
    rd(DAT, "ts_second", 32'h8000_2002);
    step();
    rd(STA, "ts_empty", 32'h0000_0001);
    step();
`else
    // Reset state.
    rd(STA, "rst_stat", 32'h0000_0001);
    ex("rst_intr", 1'b1, 32'h0, 0);
    step();
    rd(DAT, "rst_data_empty", 32'h0);
    step();

    // Single push, INTR pulse, status, pop.
    btn = 4'b0010;
    ex("intr_pulse", 1'b1, 32'h1, 1);
    step();
    rd(STA, "one_stat", 32'h0000_0100);
    ex("intr_drop", 1'b1, 32'h0, 1);
    step();
    rd(DAT, "one_data", 32'h8000_0002);
    step();
    rd(STA, "one_empty", 32'h0000_0001);
    step();
    rd(DAT, "pop_empty", 32'h0);
    step();
    rd(FRN, "foreign_rd", 32'h0);
    step();

    // FIFO ordering.
    btn = 4'b0001;
    step();
    btn = 4'b0100;
    step();
    btn = 4'b1000;
    ex("intr_third", 1'b1, 32'h1, 1);
    step();
    rd(DAT, "ord_0", 32'h8000_0001);
    ex("intr_after3", 1'b1, 32'h0, 1);
    step();
    rd(DAT, "ord_1", 32'h8000_0004);
    step();
    rd(DAT, "ord_2", 32'h8000_0008);
    step();
    rd(DAT, "ord_empty", 32'h0);
    step();

    // Fill to DEPTH and overflow.
    for (int i = 0; i < 9; i++) begin
      btn = 4'b0001;
      if (i == 7) ex("intr_8th", 1'b1, 32'h1, 1);
      if (i == 8) ex("intr_drop9", 1'b1, 32'h0, 1);
      step();
    end
    rd(STA, "ovf_stat", 32'h0000_0806);
    step();
    wr_stat(32'h2);
    step();
    rd(STA, "ovf_clr", 32'h0000_0802);
    step();

    // Full: push and pop together.
    btn = 4'b0011;
    rd(DAT, "full_pp_head", 32'h8000_0001);
    ex("intr_full_pp", 1'b1, 32'h1, 1);
    step();
    rd(STA, "full_pp_stat", 32'h0000_0802);
    step();
    for (int i = 0; i < 7; i++) begin
      rd(DAT, "drain_ones", 32'h8000_0001);
      step();
    end
    rd(DAT, "drain_last", 32'h8000_0003);
    step();
    rd(STA, "drain_empty", 32'h0000_0001);
    step();

    // Flush beats push.
    btn = 4'b0001;
    step();
    btn = 4'b0010;
    step();
    wr_stat(32'h1);
    btn = 4'b0100;
    ex("intr_flush", 1'b1, 32'h0, 1);
    step();
    rd(STA, "flush_stat", 32'h0000_0001);
    step();
    rd(DAT, "flush_data", 32'h0);
    step();

    // Reset with entries queued and a push in flight.
    for (int i = 0; i < 5; i++) begin
      btn = 4'b1000;
      step();
    end
    rst = 1'b1;
    btn = 4'b0001;
    ex("intr_in_rst", 1'b1, 32'h1, 0);
    ex("intr_post_rst", 1'b1, 32'h0, 1);
    step();
    rd(STA, "rst5_stat", 32'h0000_0001);
    ex("intr_post_rst2", 1'b1, 32'h0, 1);
    step();
    rd(DAT, "rst5_data", 32'h0);
    step();
`endif

    repeat (3) step();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_btn_event_queue.md
Name: mmio_btn_event_queue

Overview:
- Input-side MMIO peripheral: captures debounced one-shot button presses into a FIFO of events.
- The CPU drains the FIFO over IOBUS reads.
- Sits between the four Debouncer one-shot outputs and the wrapper's IOBUS_in mux; also drives the OTTER INTR line.
- Counterpart to the write-only output registers: data flows board -> CPU, and reads have side effects (pop).

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- DATA_AD, 32'h11000060, read address that returns and pops the head event.
- STAT_AD, 32'h11000064, status read address / control write address.
- TS_PRESCALE, 50000, CLK_50 cycles per timestamp tick (1 ms at 50 MHz); used only with the optional feature.

Ports:
- CLK_50  in  1  system clock, 50 MHz
- RST  in  1  synchronous, active-high reset
- BTN_PULSE  in  4  debounced one-shots; bit0 up, bit1 right, bit2 down, bit3 left
- IOBUS_ADDR  in  32  CPU bus address
- IOBUS_RD  in  1  one-cycle load strobe, asserted in the cycle the CPU samples IOBUS_in
- IOBUS_WR  in  1  store strobe
- IOBUS_OUT  in  32  store data
- RD_DATA  out  32  read data; combinational from IOBUS_ADDR and current state; 0 for foreign addresses
- INTR  out  1  one-cycle interrupt pulse

Behaviour:
- Reset (RST high at a CLK_50 edge) has priority over everything:
  - rd/wr pointers = 0, count = 0, overflow = 0, INTR = 0, timestamp counter = 0.
  - Entries queued before reset are discarded.
- Push: a cycle with BTN_PULSE != 0 enqueues one entry, mask = BTN_PULSE. Simultaneous buttons form one entry with multiple bits set.
  - Entry is visible on RD_DATA in the next cycle.
- Pop: IOBUS_RD && IOBUS_ADDR == DATA_AD && count != 0 advances the read pointer at the clock edge.
  - The read in the same cycle returns the pre-pop head.
  - A pop while empty is a no-op and returns 0.
- Simultaneous push and pop: both take effect, count unchanged.
- Full, push with no pop: entry dropped, overflow set (sticky).
- Full, push with pop: push accepted, no overflow.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH and needs $clog2(DEPTH)+1 bits.
- DATA_AD read format:
  - bit31 = valid (count != 0)
  - [27:12] = timestamp
  - [3:0] = mask
  - all other bits 0; word is 0 when empty.
- STAT_AD read format:
  - bit0 = empty, bit1 = full, bit2 = overflow
  - [15:8] = count, zero-extended
  - all other bits 0.
- STAT_AD write (IOBUS_WR):
  - IOBUS_OUT[0] = 1 flushes the FIFO (count and pointers to 0).
  - IOBUS_OUT[1] = 1 clears overflow.
  - A flush beats a same-cycle push: that push is lost and overflow is unchanged.
- INTR is registered: high for exactly one cycle following any accepted push. It is not re-asserted while entries remain.
- No FSM beyond the FIFO; control is pointer and count arithmetic.

Optional Feature:
- Macro: BTN_EVQ_TSTAMP_EN
- Defined:
  - A prescaler counts 0..TS_PRESCALE-1; on each wrap a 16-bit tick counter increments, wrapping 16'hFFFF -> 0.
  - Each entry stores the tick value at push time in RD_DATA[27:12].
  - Reset clears both counters.
- Undefined:
  - No counters are synthesised; entries are 4 bits wide; RD_DATA[27:12] = 0.

Decomposition:
- Package btn_evq_pkg:
  - DATA_AD/STAT_AD defaults
  - status bit index constants (ST_EMPTY=0, ST_FULL=1, ST_OVF=2)
  - control bit constants (CTL_FLUSH=0, CTL_CLR_OVF=1)
  - entry typedef struct {logic [15:0] ts; logic [3:0] mask;}
- Sub-module btn_evq_fifo:
  - generic synchronous FIFO with push/pop/flush and count/full/empty.
- Top-level block holds address decode, overflow, INTR, timestamp and read mux.

Test Plan:
- Reset then BTN_PULSE=4'b0010 for 1 cycle -> next cycle INTR=1 for one cycle; STAT read = 32'h0000_0100; DATA read = 32'h8000_0002 and pops; then STAT = 32'h0000_0001.
- Pushes of 4'b0001, 4'b0100, 4'b1000 -> three DATA reads return masks 1, 4, 8 in order; a fourth read returns 32'h0.
- DEPTH=8: 9 single pushes without reads -> STAT = 32'h0000_0806 (count 8, full, overflow); write STAT 32'h2 -> bit2 clears, count stays 8.
- Full queue: push 4'b0011 and DATA pop in the same cycle -> count stays 8, overflow stays 0; the 8th pop returns mask 4'b0011.
- Flush write and push in the same cycle -> STAT = 32'h1, no INTR; RST asserted with 5 entries queued -> STAT = 32'h1, INTR low.
- With BTN_EVQ_TSTAMP_EN and TS_PRESCALE=4: push at cycle 0 and at cycle 10 after reset -> timestamps 0 and 2.
